// File: rtl/seq_game_pkg.sv
// Shared state encoding, LFSR constants and width helpers for the sequence-memory game core.
package seq_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    WON,
    LOST
  } state_e;

  localparam int unsigned LFSR_W = 16;
  // Feedback taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// 16-bit Fibonacci LFSR, synchronous reset to SEED; exposes only the low OUT_W bits.
module seq_lfsr
  import seq_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int unsigned       OUT_W = 2
) (
  input  logic             iClock,
  input  logic             iResetn,
  input  logic             en_i,
  output logic [OUT_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/seq_round_engine.sv
// Sequence-memory game core: grows, replays and checks a pseudo-random key sequence.
// Optional input timeout enabled with `define SEQ_TIMEOUT_EN.
module seq_round_engine
  import seq_game_pkg::*;
#(
  parameter int unsigned       NUM_KEYS       = 4,
  parameter int unsigned       MAX_LEVEL      = 8,
  parameter int unsigned       SHOW_CYCLES    = 25_000_000,
  parameter int unsigned       GAP_CYCLES     = 12_500_000,
  parameter int unsigned       TIMEOUT_CYCLES = 250_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                           iClock,
  input  logic                           iResetn,
  input  logic                           start,
  input  logic [NUM_KEYS-1:0]            key,
  output logic [$clog2(NUM_KEYS)-1:0]    oLightIdx,
  output logic                           oLightOn,
  output logic                           oInputPhase,
  output logic [$clog2(MAX_LEVEL+1)-1:0] oLevel,
  output logic                           oWon,
  output logic                           oLost
);

  localparam int unsigned KW = $clog2(NUM_KEYS);
  localparam int unsigned LW = $clog2(MAX_LEVEL + 1);
  localparam int unsigned AW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int unsigned CW = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic            start_q, start_rise;
  logic [LW-1:0]   level_q, level_d, step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            light_q, light_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic            gap_gen_q, gap_gen_d;
  logic            won_q, lost_q, inph_q;
  logic [KW-1:0]   seq_q [MAX_LEVEL];
  logic [KW-1:0]   rand_key, key_idx, exp_key, next_key;
  logic            key_one, step_last;
`ifdef SEQ_TIMEOUT_EN
  logic [CW-1:0]   to_q, to_d;
`endif

  seq_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (KW)
  ) u_lfsr (
    .iClock  (iClock),
    .iResetn (iResetn),
    .en_i    (1'b1),
    .lfsr_o  (rand_key)
  );

  assign start_rise = start & ~start_q;
  assign exp_key    = seq_q[AW'(step_q)];
  assign next_key   = seq_q[AW'(step_q + LW'(1))];
  assign step_last  = ((step_q + LW'(1)) == level_q);

  always_comb begin
    key_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      if (key[i]) key_idx = KW'(i);
    key_one = (key != '0) && ((key & (key - NUM_KEYS'(1))) == '0);
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    light_d   = 1'b0;
    idx_d     = idx_q;
    gap_gen_d = gap_gen_q;
`ifdef SEQ_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      IDLE, WON, LOST: ;
      GEN: begin
        // buf[0] is written this same cycle on the first round, so bypass it
        idx_d     = (level_q == '0) ? rand_key : seq_q[0];
        level_d   = level_q + LW'(1);
        step_d    = '0;
        cnt_d     = SHOW_LOAD;
        light_d   = 1'b1;
        gap_gen_d = 1'b0;
        state_d   = SHOW_ON;
      end
      SHOW_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = SHOW_OFF;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          light_d = 1'b1;
        end
      end
      SHOW_OFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (gap_gen_q) begin
          state_d = GEN;
        end else if (step_last) begin
          step_d  = '0;
          state_d = INPUT;
`ifdef SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          step_d  = step_q + LW'(1);
          idx_d   = next_key;
          cnt_d   = SHOW_LOAD;
          light_d = 1'b1;
          state_d = SHOW_ON;
        end
      end
      INPUT: begin
        if (light_q && cnt_q != '0) begin
          light_d = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end
`ifdef SEQ_TIMEOUT_EN
        to_d = to_q + CW'(1);
`endif
        if (key != '0) begin
          if (key_one && key_idx == exp_key) begin
`ifdef SEQ_TIMEOUT_EN
            to_d = '0;
`endif
            if (step_last) begin
              // the last key of a round is not echoed; the gap leads into the next GEN
              light_d = 1'b0;
              if (level_q == LW'(MAX_LEVEL)) begin
                state_d = WON;
              end else begin
                cnt_d     = GAP_LOAD;
                gap_gen_d = 1'b1;
                state_d   = SHOW_OFF;
              end
            end else begin
              step_d  = step_q + LW'(1);
              idx_d   = key_idx;
              cnt_d   = SHOW_LOAD;
              light_d = 1'b1;
            end
          end else begin
            light_d = 1'b0;
            state_d = LOST;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (to_q == CW'(TIMEOUT_CYCLES - 1)) begin
          light_d = 1'b0;
          state_d = LOST;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (start_rise) begin
      state_d = GEN;
      level_d = '0;
      step_d  = '0;
      light_d = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      level_q   <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      light_q   <= 1'b0;
      idx_q     <= '0;
      gap_gen_q <= 1'b0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      inph_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      level_q   <= level_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      light_q   <= light_d;
      idx_q     <= idx_d;
      gap_gen_q <= gap_gen_d;
      won_q     <= (state_d == WON);
      lost_q    <= (state_d == LOST);
      inph_q    <= (state_d == INPUT);
`ifdef SEQ_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  always_ff @(posedge iClock) begin
    if (state_q == GEN) seq_q[AW'(level_q)] <= rand_key;
  end

  assign oLightIdx   = idx_q;
  assign oLightOn    = light_q;
  assign oInputPhase = inph_q;
  assign oLevel      = level_q;
  assign oWon        = won_q;
  assign oLost       = lost_q;

endmodule

// File: tb/tb_seq_round_engine.sv
// Scoreboard bench for seq_round_engine: stimulus queues expected show/echo/verdict events, a monitor checks them.
module tb_seq_round_engine;

  localparam int unsigned ML   = 3;
  localparam int unsigned SHOW = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned TO   = 50;

  logic       iClock  = 1'b0;
  logic       iResetn = 1'b0;
  logic       start   = 1'b0;
  logic [3:0] key     = '0;
  logic [1:0] oLightIdx, oLevel;
  logic       oLightOn, oInputPhase, oWon, oLost;

  always #5 iClock = ~iClock;

  seq_round_engine #(
    .NUM_KEYS       (4),
    .MAX_LEVEL      (ML),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .iClock      (iClock),
    .iResetn     (iResetn),
    .start       (start),
    .key         (key),
    .oLightIdx   (oLightIdx),
    .oLightOn    (oLightOn),
    .oInputPhase (oInputPhase),
    .oLevel      (oLevel),
    .oWon        (oWon),
    .oLost       (oLost)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  // Reference LFSR, taps 16,14,13,11, running every cycle like the design's
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_last = 16'hACE1;
  always @(posedge iClock) begin
    cyc    <= cyc + 1;
    m_last <= m_lfsr;
    m_lfsr <= !iResetn ? 16'hACE1
                       : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct { logic [1:0] idx; int unsigned len; int unsigned gap; } show_t;
  typedef struct { logic [1:0] idx; int unsigned cyc; int unsigned len; } echo_t;
  typedef struct { bit won; int unsigned cyc; } verd_t;

  show_t show_q[$];
  echo_t echo_q[$];
  verd_t verd_q[$];
  logic [1:0] exp_seq [ML];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs just after each falling edge, pops expectations when the DUT presents an event
  logic        prev_light = 1'b0, prev_won = 1'b0, prev_lost = 1'b0;
  bit          run_echo, gap_pend = 1'b0;
  int unsigned run_len, exp_len, dark, exp_gap;
  show_t       ms;
  echo_t       me;
  verd_t       mv;

  always begin
    @(negedge iClock);
    #1;
    if (gap_pend) begin
      if (!oLightOn && !oInputPhase) dark++;
      else begin
        check("show gap", dark, exp_gap);
        gap_pend = 1'b0;
      end
    end
    if (oLightOn && !prev_light) begin
      run_len  = 1;
      run_echo = oInputPhase;
      if (oInputPhase) begin
        check("echo queued", echo_q.size() != 0, 1);
        if (echo_q.size() != 0) begin
          me = echo_q.pop_front();
          check("echo idx", oLightIdx, me.idx);
          check("echo cycle", cyc, me.cyc);
          exp_len = me.len;
        end
      end else begin
        check("show queued", show_q.size() != 0, 1);
        if (show_q.size() != 0) begin
          ms = show_q.pop_front();
          check("show idx", oLightIdx, ms.idx);
          exp_len = ms.len;
          exp_gap = ms.gap;
        end
      end
    end else if (oLightOn && prev_light) begin
      run_len++;
    end else if (!oLightOn && prev_light) begin
      check(run_echo ? "echo length" : "show length", run_len, exp_len);
      if (!run_echo) begin
        gap_pend = 1'b1;
        dark     = 1;
      end
    end
    if ((oWon && !prev_won) || (oLost && !prev_lost)) begin
      check("verdict queued", verd_q.size() != 0, 1);
      if (verd_q.size() != 0) begin
        mv = verd_q.pop_front();
        check("verdict won", oWon, mv.won);
        check("verdict lost", oLost, !mv.won);
        check("verdict cycle", cyc, mv.cyc);
      end
    end
    prev_light = oLightOn;
    prev_won   = oWon;
    prev_lost  = oLost;
  end

  task automatic wait_level(input int unsigned lvl, output int unsigned dt);
    int unsigned t0 = cyc;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iClock);
      if (oLevel == lvl) begin ok = 1'b1; break; end
    end
    check("level reached", ok, 1);
    dt = cyc - t0;
  endtask

  task automatic wait_inph();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iClock);
      if (oInputPhase) begin ok = 1'b1; break; end
    end
    check("input phase reached", ok, 1);
  endtask

  task automatic wait_dark();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iClock);
      if (!oLightOn) begin ok = 1'b1; break; end
    end
    check("echo ended", ok, 1);
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    @(negedge iClock);
    key = '0;
  endtask

  task automatic start_game();
    int unsigned dt;
    start = 1'b0;
    @(negedge iClock);
    start = 1'b1;
    wait_level(1, dt);
    check("start to level1 cycles", dt, 2);
    check("start oLightOn", oLightOn, 1);
    check("start oLost", oLost, 0);
    check("start oWon", oWon, 0);
  endtask

  // Called on the first lit cycle of round lvl; the new element came from the GEN cycle's LFSR
  task automatic play_round(input int unsigned lvl, input int wrong_step);
    show_t s;
    echo_t e;
    verd_t v;
    int unsigned t;
    exp_seq[lvl-1] = m_last[1:0];
    check("round level", oLevel, lvl);
    for (int unsigned i = 0; i < lvl; i++) begin
      s.idx = exp_seq[i]; s.len = SHOW; s.gap = GAP;
      show_q.push_back(s);
    end
    wait_inph();
    for (int unsigned i = 0; i < lvl; i++) begin
      t = cyc;
      if (int'(i) == wrong_step) begin
        v.won = 1'b0; v.cyc = t + 1;
        verd_q.push_back(v);
        press(4'b0001 << (exp_seq[i] + 2'd1));
        return;
      end else if (i < lvl - 1) begin
        e.idx = exp_seq[i]; e.cyc = t + 1; e.len = SHOW;
        echo_q.push_back(e);
        press(4'b0001 << exp_seq[i]);
        wait_dark();
      end else begin
        if (lvl == ML) begin
          v.won = 1'b1; v.cyc = t + 1;
          verd_q.push_back(v);
        end
        press(4'b0001 << exp_seq[i]);
      end
    end
  endtask

  int unsigned dt, tin;
  bit          seen;
  show_t       s0;
  verd_t       v0;

  initial begin
    repeat (2) @(negedge iClock);
    check("reset oLevel", oLevel, 0);
    check("reset oLightOn", oLightOn, 0);
    check("reset oWon", oWon, 0);
    check("reset oLost", oLost, 0);
    check("reset oInputPhase", oInputPhase, 0);
    check("reset oLightIdx", oLightIdx, 0);
    iResetn = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClock);
      if (i == 3) key = 4'b0100;
      else        key = '0;
      seen = seen | oLightOn | oWon | oLost | oInputPhase | (oLevel != 0);
    end
    key = '0;
    check("idle activity seen", seen, 0);

    // Full win: rounds of 1, 2 and 3 elements
    start_game();
    play_round(1, -1);
    wait_level(2, dt);
    play_round(2, -1);
    wait_level(3, dt);
    play_round(3, -1);
    check("win oWon", oWon, 1);
    check("win oLevel", oLevel, 3);
    check("win oInputPhase", oInputPhase, 0);
    check("win oLightOn", oLightOn, 0);

    // Restart from WON, wrong key on step 1 of round 2
    start_game();
    play_round(1, -1);
    wait_level(2, dt);
    play_round(2, 1);
    check("lost oLost", oLost, 1);
    check("lost oLightOn", oLightOn, 0);
    check("lost oInputPhase", oInputPhase, 0);
    for (int unsigned i = 0; i < 2; i++) begin
      press(4'b0001 << exp_seq[i]);
      repeat (3) @(negedge iClock);
    end
    check("after-loss oLost", oLost, 1);
    check("after-loss oLevel", oLevel, 2);

    // Restart from LOST; key during SHOW_ON ignored, then a two-bit key loses
    start_game();
    exp_seq[0] = m_last[1:0];
    s0.idx = exp_seq[0]; s0.len = SHOW; s0.gap = GAP;
    show_q.push_back(s0);
    press(4'b0001 << (exp_seq[0] + 2'd1));
    check("show key ignored oLightOn", oLightOn, 1);
    wait_inph();
    check("show key ignored oLost", oLost, 0);
    check("show key ignored oLevel", oLevel, 1);
    v0.won = 1'b0; v0.cyc = cyc + 1;
    verd_q.push_back(v0);
    press(4'b0011);
    check("multi-key oLost", oLost, 1);

    // Input timeout behaviour
    start_game();
    exp_seq[0] = m_last[1:0];
    s0.idx = exp_seq[0];
    show_q.push_back(s0);
    wait_inph();
    tin = cyc;
`ifdef SEQ_TIMEOUT_EN
    v0.won = 1'b0; v0.cyc = tin + TO;
    verd_q.push_back(v0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge iClock);
      if (oLost) begin seen = 1'b1; break; end
    end
    check("timeout oLost", seen, 1);
    check("timeout cycles", cyc - tin, TO);
`else
    repeat (1000) @(negedge iClock);
    check("no-timeout oInputPhase", oInputPhase, 1);
    check("no-timeout oLost", oLost, 0);
    check("no-timeout oLevel", oLevel, 1);
    check("no-timeout waited", cyc - tin, 1000);
`endif

    repeat (5) @(negedge iClock);
    check("show queue drained", show_q.size(), 0);
    check("echo queue drained", echo_q.size(), 0);
    check("verdict queue drained", verd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
